// File: rtl/ring_arbiter.sv
// Four-way round-robin arbiter with bounded tenure and a recovery gap.
// Grants are registered; a forced release raises a one-cycle timeout.
module ring_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       last,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_END = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RECOVER
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_nx;
  logic [3:0]    ptr;
  logic [3:0]    ptr_nx;
  logic [3:0]    gnt_nx;
  logic [1:0]    owner_nx;
  logic          busy_nx;
  logic          timeout_nx;

  logic [1:0]    ptr_idx;
  logic [1:0]    sel_idx;
  logic [1:0]    cand;
  logic          sel_vld;
  logic [3:0]    sel_oh;
  logic [3:0]    sel_rot;
  logic          own_req;
  logic          expire;
  logic          done;

  always_comb begin
    unique case (1'b1)
      ptr[0]:  ptr_idx = 2'd0;
      ptr[1]:  ptr_idx = 2'd1;
      ptr[2]:  ptr_idx = 2'd2;
      ptr[3]:  ptr_idx = 2'd3;
      default: ptr_idx = 2'd0;
    endcase
  end

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = ptr_idx;
    cand    = ptr_idx;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_idx + 2'(i);
      if (req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign sel_oh  = 4'b0001 << sel_idx;
  assign sel_rot = {sel_oh[2:0], sel_oh[3]};

  assign own_req = req[owner];
  assign expire  = (hold_cnt == HOLD_END);
  assign done    = !own_req || last || expire;

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    owner_nx   = owner;
    hold_nx    = hold_cnt;
    ptr_nx     = ptr;
    busy_nx    = busy;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_nx  = 4'b0000;
        busy_nx = 1'b0;
        if (en && sel_vld) begin
          state_nx = GRANT;
          gnt_nx   = sel_oh;
          owner_nx = sel_idx;
          hold_nx  = '0;
          ptr_nx   = sel_rot;
          busy_nx  = 1'b1;
        end
      end
      GRANT: begin
        if (done) begin
          state_nx   = RECOVER;
          gnt_nx     = 4'b0000;
          busy_nx    = 1'b0;
          hold_nx    = '0;
          timeout_nx = expire && own_req && !last;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      RECOVER: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      owner    <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= 4'b0001;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      busy     <= busy_nx;
      timeout  <= timeout_nx;
      hold_cnt <= hold_nx;
      ptr      <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_ring_arbiter.sv
// Scenario bench for ring_arbiter: per-cycle expectations queued at
// drive time and popped after each clock edge.
module tb_ring_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       last;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
  } obs_t;

  typedef struct packed {
    logic       en;
    logic [3:0] req;
    logic       last;
    obs_t       exp;
  } stim_t;

  obs_t expq[$];

  ring_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req),
    .last(last),
    .gnt(gnt),
    .owner(owner),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t ob(input logic [3:0] g, input logic [1:0] o,
                              input logic b, input logic t);
    ob = '{gnt: g, owner: o, busy: b, timeout: t};
  endfunction

  function automatic stim_t mk(input logic e, input logic [3:0] r,
                               input logic l, input obs_t x);
    mk = '{en: e, req: r, last: l, exp: x};
  endfunction

  function automatic obs_t observe();
    observe = '{gnt: gnt, owner: owner, busy: busy, timeout: timeout};
  endfunction

  task automatic drive(input stim_t s);
    en   = s.en;
    req  = s.req;
    last = s.last;
    expq.push_back(s.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t want;
    rst  = 1'b0;
    en   = 1'b1;
    req  = 4'b1111;
    last = 1'b0;
    @(posedge clk);
    #1;
    expq.push_back(ob(4'b0000, 2'd0, 1'b0, 1'b0));
    want = expq.pop_front();
    got  = observe();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset got %b want %b", got, want);
    end
    en   = 1'b0;
    req  = 4'b0000;
    rst  = 1'b1;
  endtask

  task automatic test_single();
    stim_t s[$];
    obs_t  got;
    obs_t  want;
    s.push_back(mk(1, 4'b0100, 0, ob(4'b0100, 2, 1, 0)));
    s.push_back(mk(1, 4'b0100, 0, ob(4'b0100, 2, 1, 0)));
    s.push_back(mk(1, 4'b0100, 0, ob(4'b0100, 2, 1, 0)));
    s.push_back(mk(1, 4'b0100, 1, ob(4'b0000, 2, 0, 0)));
    s.push_back(mk(1, 4'b0100, 1, ob(4'b0000, 2, 0, 0)));
    s.push_back(mk(1, 4'b0100, 0, ob(4'b0100, 2, 1, 0)));
    s.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 2, 0, 0)));
    s.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 2, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      want = expq.pop_front();
      got  = observe();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL single[%0d] got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s[$];
    obs_t  got;
    obs_t  want;
    s.push_back(mk(1, 4'b1001, 1, ob(4'b1000, 3, 1, 0)));
    s.push_back(mk(1, 4'b1001, 1, ob(4'b0000, 3, 0, 0)));
    s.push_back(mk(1, 4'b1001, 1, ob(4'b0000, 3, 0, 0)));
    s.push_back(mk(1, 4'b1001, 1, ob(4'b0001, 0, 1, 0)));
    s.push_back(mk(1, 4'b0000, 1, ob(4'b0000, 0, 0, 0)));
    s.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      want = expq.pop_front();
      got  = observe();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL wrap[%0d] got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_round_robin();
    stim_t      s[$];
    obs_t       got;
    obs_t       want;
    logic [1:0] o;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      o = 2'(k % 4);
      s.push_back(mk(1, 4'b1111, 1, ob(4'b0001 << o, o, 1, 0)));
      if (k < 4) begin
        s.push_back(mk(1, 4'b1111, 1, ob(4'b0000, o, 0, 0)));
        s.push_back(mk(1, 4'b1111, 1, ob(4'b0000, o, 0, 0)));
      end
    end
    s.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 0, 0, 0)));
    s.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      want = expq.pop_front();
      got  = observe();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL round_robin[%0d] got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s[$];
    obs_t  got;
    obs_t  want;
    for (int k = 0; k < 8; k++)
      s.push_back(mk(1, 4'b0001, 0, ob(4'b0001, 0, 1, 0)));
    s.push_back(mk(1, 4'b0001, 0, ob(4'b0000, 0, 0, 1)));
    s.push_back(mk(1, 4'b0001, 0, ob(4'b0000, 0, 0, 0)));
    for (int k = 0; k < 8; k++)
      s.push_back(mk(1, 4'b0001, 0, ob(4'b0001, 0, 1, 0)));
    s.push_back(mk(1, 4'b0001, 1, ob(4'b0000, 0, 0, 0)));
    s.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      want = expq.pop_front();
      got  = observe();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL timeout[%0d] got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_enable_reset();
    stim_t s[$];
    stim_t t[$];
    obs_t  got;
    obs_t  want;
    for (int k = 0; k < 3; k++)
      s.push_back(mk(0, 4'b0010, 0, ob(4'b0000, 0, 0, 0)));
    s.push_back(mk(1, 4'b0010, 0, ob(4'b0010, 1, 1, 0)));
    s.push_back(mk(0, 4'b0010, 0, ob(4'b0010, 1, 1, 0)));
    s.push_back(mk(0, 4'b0010, 0, ob(4'b0010, 1, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      want = expq.pop_front();
      got  = observe();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL enable[%0d] got %b want %b", i, got, want);
      end
    end
    #2;
    rst = 1'b0;
    expq.push_back(ob(4'b0000, 0, 0, 0));
    #1;
    want = expq.pop_front();
    got  = observe();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL async_reset got %b want %b", got, want);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    t.push_back(mk(1, 4'b1111, 1, ob(4'b0001, 0, 1, 0)));
    t.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 0, 0, 0)));
    t.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 0, 0, 0)));
    foreach (t[i]) begin
      drive(t[i]);
      want = expq.pop_front();
      got  = observe();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL post_reset[%0d] got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_owner_drop();
    stim_t s[$];
    obs_t  got;
    obs_t  want;
    s.push_back(mk(1, 4'b0100, 0, ob(4'b0100, 2, 1, 0)));
    s.push_back(mk(1, 4'b1110, 0, ob(4'b0100, 2, 1, 0)));
    s.push_back(mk(1, 4'b0000, 0, ob(4'b0000, 2, 0, 0)));
    s.push_back(mk(1, 4'b0000, 1, ob(4'b0000, 2, 0, 0)));
    s.push_back(mk(1, 4'b0000, 1, ob(4'b0000, 2, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      want = expq.pop_front();
      got  = observe();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL owner_drop[%0d] got %b want %b", i, got, want);
      end
    end
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    req  = 4'b0000;
    last = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_timeout();
    test_enable_reset();
    test_owner_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles per tenure; legal range 2..256.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  arbitration enable; 0 blocks new grants only.
REQ-005 Port: req  input  4  request per requester; bit i = requester i.
REQ-006 Port: last  input  1  current owner's final cycle; qualified by gnt.
REQ-007 Port: gnt  output  4  registered one-hot grant, or all-zero.
REQ-008 Port: owner  output  2  registered index of granted requester; holds last value when gnt=0.
REQ-009 Port: busy  output  1  registered; 1 while in GRANT.
REQ-010 Port: timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-011 The block SHALL implement three states: IDLE, GRANT, RECOVER.
REQ-012 The block SHALL keep a one-hot rotating priority pointer ptr[3:0].
REQ-013 In IDLE with en=1 and req!=0, selection SHALL be the first set req bit searching circularly upward from ptr's bit position.
REQ-014 On that edge, the block SHALL enter GRANT, load gnt with the selected one-hot and owner with its index, clear hold_cnt, and set ptr to the selected bit rotated left by one (bit 3 wraps to bit 0).
REQ-015 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with gnt=0 and ptr unchanged.
REQ-016 Latency: req sampled in IDLE at edge N SHALL give gnt valid from edge N to edge N+1.
REQ-017 In GRANT, hold_cnt SHALL increment each cycle; its width is ceil(log2(MAX_HOLD)) bits and it SHALL never wrap within a tenure.
REQ-018 A GRANT cycle SHALL end the tenure if req[owner]=0, or last=1, or hold_cnt=MAX_HOLD-1.
REQ-019 On tenure end, gnt and busy SHALL clear on the next edge and the state SHALL become RECOVER.
REQ-020 Tenure length SHALL be 1..MAX_HOLD cycles.
REQ-021 timeout SHALL be 1 for exactly the RECOVER cycle only when the release was caused solely by hold_cnt=MAX_HOLD-1, with req[owner]=1 and last=0.
REQ-022 Simultaneous last=1 and count expiry SHALL count as a normal release, with timeout=0.
REQ-023 RECOVER SHALL last exactly one cycle with gnt=0 and SHALL then go to IDLE unconditionally.
REQ-024 Minimum gap between consecutive tenures SHALL be two gnt=0 cycles (RECOVER, then IDLE).
REQ-025 en=0 during GRANT SHALL NOT affect the current tenure.
REQ-026 req changes on non-owner bits during GRANT SHALL be ignored until the next IDLE.
REQ-027 last while gnt=0 SHALL be ignored.
REQ-028 gnt SHALL never have more than one bit set.
REQ-029 A granted requester SHALL NOT be selected again while any other requester has been continuously requesting (round-robin fairness, worst-case wait 3 tenures).

Reset
REQ-030 Asserting rst=0 SHALL immediately force: state=IDLE, gnt=4'b0000, owner=2'd0, busy=0, timeout=0, hold_cnt=0, ptr=4'b0001.
REQ-031 Reset mid-tenure SHALL drop gnt asynchronously, without a RECOVER cycle.
REQ-032 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst=1.

Verification
REQ-033 Bench SHALL cover single requester, MAX_HOLD=8: req=4'b0100 held, last pulsed in the 3rd grant cycle -> gnt=4'b0100 for 3 cycles, owner=2, then 2 zero cycles, then re-grant of 4'b0100.
REQ-034 Bench SHALL cover round-robin: req=4'b1111 held, last tied to 1 after reset -> grant order 0,1,2,3,0 with 1-cycle tenures separated by 2 idle cycles.
REQ-035 Bench SHALL cover timeout: req=4'b0001 held, last=0, MAX_HOLD=8 -> gnt=4'b0001 exactly 8 cycles, then timeout=1 for 1 cycle, then re-grant 2 cycles later.
REQ-036 Bench SHALL cover wrap priority: ptr at bit 3 after granting 2, req=4'b1001 -> grant 3; next tenure grants 0.
REQ-037 Bench SHALL cover enable and reset: en=0 with req=4'b0010 -> no grant; en=1 -> gnt=4'b0010 next edge; rst=0 mid-tenure -> gnt=0 immediately, ptr=4'b0001.
REQ-038 Bench SHALL cover owner drop: owner deasserts req in grant cycle 2 with last=0 -> gnt clears next edge, timeout stays 0.
